// File: rtl/data_memory_port.sv
// data_memory_port
//   Data-memory responder for the working-register path. Serves loads (MR)
//   into the working register and stores (MW) of it, from an internal
//   2**ADDR_W x DATA_W RAM with WAIT_STATES cycles of port occupancy per
//   access.
//
//   Optional feature macro: WRITE_BUFFER_EN
//     defined   : stores are posted into a WBUF_DEPTH-entry FIFO and drained
//                 to the RAM when the port is idle and no load is requested;
//                 loads forward the newest matching FIFO entry.
//     undefined : stores occupy the access FSM exactly like loads.
//
// Ports
//   clk       rising-edge clock
//   nreset    asynchronous active-low reset
//   MR / MW   load / store request, held by the CPU until accepted
//   Addr      access address (captured on accept)
//   W_IN      store data (captured on accept)
//   W_MEM_IN  load data, holds the last completed load
//   Rd_valid  one-cycle pulse when W_MEM_IN has been updated
//   Mem_busy  high = requests are ignored at the coming edge
//   Err       one-cycle pulse after an MR&MW request was dropped
module data_memory_port #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter int WBUF_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] W_IN,
  output logic [DATA_W-1:0] W_MEM_IN,
  output logic              Rd_valid,
  output logic              Mem_busy,
  output logic              Err
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  if (WBUF_DEPTH < 1 || WAIT_STATES < 0) begin : g_param_check
    $error("data_memory_port: WBUF_DEPTH must be >= 1 and WAIT_STATES >= 0");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              load_q, load_nxt;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // A new access entering the port this edge, and what it carries.
  logic              start;
  logic              start_load;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_data;

  // The access actually performed on the RAM this edge.
  logic              do_acc;
  logic              acc_load;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic [DATA_W-1:0] rd_data;

  logic busy_acc;
  logic err_req;

  assign busy_acc = (state == ACCESS);

`ifdef WRITE_BUFFER_EN
  localparam int WB_CW = $clog2(WBUF_DEPTH + 1);

  // Entry 0 is the oldest; higher indices are newer.
  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [WB_CW-1:0]  wb_cnt;
  logic [WB_CW-1:0]  wb_wr_idx;
  logic              wb_full, wb_push, wb_pop;
  logic              load_acc, drain_start;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign wb_full     = (wb_cnt == WB_CW'(WBUF_DEPTH));
  assign Mem_busy    = busy_acc | (MW & wb_full);
  assign wb_push     = MW & ~MR & ~Mem_busy;
  assign load_acc    = MR & ~MW & ~Mem_busy;
  // Loads win over drains: a pending MR blocks the drain from starting.
  assign drain_start = ~busy_acc & ~MR & (wb_cnt != '0);
  assign start       = load_acc | drain_start;
  assign start_load  = load_acc;
  assign start_addr  = load_acc ? Addr : wb_addr[0];
  assign start_data  = wb_data[0];
  // The head entry stays in the FIFO until its RAM write actually lands.
  assign wb_pop      = do_acc & ~acc_load;
  assign wb_wr_idx   = wb_cnt - WB_CW'(wb_pop);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) wb_cnt <= '0;
    else         wb_cnt <= wb_cnt + WB_CW'(wb_push) - WB_CW'(wb_pop);
  end

  always_ff @(posedge clk) begin
    if (wb_pop) begin
      for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
        wb_addr[i] <= wb_addr[i+1];
        wb_data[i] <= wb_data[i+1];
      end
    end
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (wb_push && wb_wr_idx == WB_CW'(i)) begin
        wb_addr[i] <= Addr;
        wb_data[i] <= W_IN;
      end
    end
  end

  // Newest match wins: later (newer) entries override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (WB_CW'(i) < wb_cnt && wb_addr[i] == acc_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[i];
      end
    end
  end

  assign rd_data = fwd_hit ? fwd_data : mem[acc_addr];
`else
  assign Mem_busy   = busy_acc;
  assign start      = (MR ^ MW) & ~busy_acc;
  assign start_load = MR;
  assign start_addr = Addr;
  assign start_data = W_IN;
  assign rd_data    = mem[acc_addr];
`endif

  // Conflicting request: dropped, flagged one cycle later.
  assign err_req = MR & MW & ~Mem_busy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    load_nxt  = load_q;
    do_acc    = 1'b0;
    acc_load  = load_q;
    acc_addr  = addr_q;
    acc_data  = data_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (WAIT_STATES == 0) begin
            // Zero wait states: the RAM is touched at the accept edge.
            do_acc   = 1'b1;
            acc_load = start_load;
            acc_addr = start_addr;
            acc_data = start_data;
          end else begin
            state_nxt = ACCESS;
            cnt_nxt   = CNT_LAST;
            addr_nxt  = start_addr;
            data_nxt  = start_data;
            load_nxt  = start_load;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          do_acc    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      W_MEM_IN <= '0;
      Rd_valid <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      load_q   <= load_nxt;
      Rd_valid <= do_acc & acc_load;
      Err      <= err_req;
      if (do_acc && acc_load) W_MEM_IN <= rd_data;
    end
  end

  // RAM contents survive reset; a store aborted by reset never reaches here
  // because reset returns the FSM to IDLE before the access edge.
  always_ff @(posedge clk) begin
    if (do_acc && !acc_load) mem[acc_addr] <= acc_data;
  end

endmodule

// File: tb/tb_data_memory_port.sv
module tb_data_memory_port;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          MR = 1'b0, MW = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [DW-1:0] W_IN = '0;
  logic [DW-1:0] W_MEM_IN;
  logic          Rd_valid, Mem_busy, Err;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_port #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .WBUF_DEPTH(2)) dut (
    .clk(clk), .nreset(nreset), .MR(MR), .MW(MW), .Addr(Addr), .W_IN(W_IN),
    .W_MEM_IN(W_MEM_IN), .Rd_valid(Rd_valid), .Mem_busy(Mem_busy), .Err(Err)
  );

  always #5 clk = ~clk;

`ifdef WRITE_BUFFER_EN
  localparam bit WB_MODE = 1'b1;
`else
  localparam bit WB_MODE = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge, hold it until the port takes it, and
  // return at the negedge right after the accept edge with inputs dropped.
  task automatic issue(input logic mr, input logic mw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    MR = mr; MW = mw; Addr = a; W_IN = d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Mem_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: request never accepted, Mem_busy stuck at %0b", Mem_busy);
    end
    @(posedge clk);
    @(negedge clk);
    MR = 1'b0; MW = 1'b0;
  endtask

  // Watch samples k=0..WS+1 after an accept edge (k=0 is the current negedge).
  task automatic observe(input string tag, input bit is_load, input bit is_err,
                         input logic [DW-1:0] exp_data);
    int rv_cnt, rv_at;
    rv_cnt = 0; rv_at = -1;
    for (int k = 0; k <= WS + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (Rd_valid === 1'b1) begin rv_cnt++; rv_at = k; end
      chk($sformatf("%s_err_k%0d", tag, k), Err, (is_err && k == 0));
      if (!WB_MODE) chk($sformatf("%s_busy_k%0d", tag, k), Mem_busy, (!is_err && k < WS));
    end
    chk({tag, "_rv_count"}, rv_cnt, is_load ? 1 : 0);
    if (is_load) begin
      chk({tag, "_rv_latency"}, rv_at, WS);
      chk({tag, "_data"}, W_MEM_IN, exp_data);
    end
  endtask

  typedef struct {
    logic          mr, mw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err, exp_rv;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    int            due;
    bit            known;
    logic [DW-1:0] d;
  } ld_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt[10];
    int   rvc;
    bit   ok;

    vt[0] = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 8'h10, 16'h1234, 1'b1, 1'b0, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vt[4] = '{1'b0, 1'b1, 8'h00, 16'h0001, 1'b0, 1'b0, 16'h0000};
    vt[5] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    vt[6] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
    vt[7] = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0001};
    vt[8] = '{1'b0, 1'b1, 8'hFF, 16'h0F0F, 1'b0, 1'b0, 16'h0000};
    vt[9] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b1, 16'h0F0F};

    // Reset state
    #12;
    chk("rst_wmem", W_MEM_IN, 0);
    chk("rst_rv", Rd_valid, 0);
    chk("rst_busy", Mem_busy, 0);
    chk("rst_err", Err, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].mr, vt[i].mw, vt[i].addr, vt[i].wdata);
      observe($sformatf("vec%0d", i), vt[i].exp_rv, vt[i].exp_err, vt[i].exp_data);
    end

    // Async reset mid-cycle while Rd_valid is high
    issue(1'b1, 1'b0, 8'h10, 16'h0);
    for (int k = 1; k <= WS; k++) @(negedge clk);
    chk("s1_rv_before", Rd_valid, 1);
    chk("s1_data_before", W_MEM_IN, 16'hBEEF);
    #1 nreset = 1'b0;
    #1;
    chk("s1_wmem", W_MEM_IN, 0);
    chk("s1_rv", Rd_valid, 0);
    chk("s1_busy", Mem_busy, 0);
    chk("s1_err", Err, 0);
    #1 nreset = 1'b1;
    @(negedge clk);

    // Request held through Mem_busy is accepted exactly once
    issue(1'b0, 1'b1, 8'h20, 16'h7777);
    MR = 1'b1; Addr = 8'h20;
    #1;
    if (!WB_MODE) chk("s4_busy_held", Mem_busy, 1);
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Mem_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("s4_accepted", ok, 1);
    @(posedge clk);
    @(negedge clk);
    MR = 1'b0;
    rvc = 0;
    for (int k = 0; k <= WS + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (Rd_valid === 1'b1) begin
        rvc++;
        chk("s4_data", W_MEM_IN, 16'h7777);
      end
    end
    chk("s4_rv_count", rvc, 1);

    // Store aborted by reset during ACCESS is not written
    issue(1'b0, 1'b1, 8'h10, 16'h5555);
    #1 nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h10, 16'h0);
    observe("s5_store_abort", 1'b1, 1'b0, 16'hBEEF);

    // Load aborted by reset during ACCESS
    issue(1'b1, 1'b0, 8'h10, 16'h0);
    #1 nreset = 1'b0;
    #1;
    chk("s5_rst_wmem", W_MEM_IN, 0);
    @(negedge clk);
    nreset = 1'b1;
    rvc = 0;
    for (int k = 0; k < WS + 3; k++) begin
      @(negedge clk);
      if (Rd_valid !== 1'b0) rvc++;
      if (W_MEM_IN !== '0) rvc++;
    end
    chk("s5_no_rv_no_data", rvc, 0);
    issue(1'b1, 1'b0, 8'h10, 16'h0);
    observe("s5_reload", 1'b1, 1'b0, 16'hBEEF);

`ifdef WRITE_BUFFER_EN
    // Posted stores, forwarding and FIFO-full back-pressure
    repeat (12) @(negedge clk);
    MW = 1'b1; Addr = 8'h30; W_IN = 16'h1111;
    #1 chk("s6_busy_first", Mem_busy, 0);
    @(negedge clk);
    W_IN = 16'h2222;
    #1 chk("s6_busy_second", Mem_busy, 0);
    @(negedge clk);
    W_IN = 16'h3333;
    #1 chk("s6_busy_full", Mem_busy, 1);
    @(negedge clk);
    MW = 1'b0;
    issue(1'b1, 1'b0, 8'h30, 16'h0);
    observe("s6_fwd", 1'b1, 1'b0, 16'h2222);
    repeat (12) @(negedge clk);
    issue(1'b1, 1'b0, 8'h30, 16'h0);
    observe("s6_after_drain", 1'b1, 1'b0, 16'h2222);
`endif

    // Randomized traffic against a transaction-level model
    repeat (12) @(negedge clk);
    begin
      logic [DW-1:0] mmem [8];
      bit            known [8];
      ld_t           q[$];
      int            cyc, bcnt;
      bit            pend, acc, exp_rv, exp_err, exp_known;
      logic [DW-1:0] exp_w;
      logic          cmr, cmw;
      logic [2:0]    ca;
      logic [DW-1:0] cd;
      int            r;
      for (int i = 0; i < 8; i++) begin known[i] = 1'b0; mmem[i] = '0; end
      cyc = 0; bcnt = 0; pend = 1'b0; exp_rv = 1'b0; exp_err = 1'b0;
      exp_known = 1'b0; exp_w = '0; cmr = 1'b0; cmw = 1'b0; ca = '0; cd = '0;
      for (int t = 0; t < 600; t++) begin
        chk("rnd_rv", Rd_valid, exp_rv);
        chk("rnd_err", Err, exp_err);
        if (!WB_MODE) chk("rnd_busy", Mem_busy, (bcnt > 0));
        if (exp_rv && exp_known) chk("rnd_data", W_MEM_IN, exp_w);
        if (!pend) begin
          r = $urandom_range(0, 9);
          ca = 3'($urandom_range(0, 7));
          cd = 16'($urandom);
          cmr = (r <= 3) || (r == 7);
          cmw = (r >= 4 && r <= 7);
          pend = cmr | cmw;
        end
        MR = cmr; MW = cmw; Addr = {5'b01000, ca}; W_IN = cd;
        #1;
        acc = pend && (WB_MODE ? !Mem_busy : (bcnt == 0));
        @(posedge clk);
        exp_err = acc && cmr && cmw;
        if (bcnt > 0) bcnt--;
        if (acc && !(cmr && cmw)) begin
          if (cmr) q.push_back('{cyc + WS, known[ca], mmem[ca]});
          else begin mmem[ca] = cd; known[ca] = 1'b1; end
          bcnt = WS;
        end
        if (acc) begin pend = 1'b0; cmr = 1'b0; cmw = 1'b0; end
        exp_rv = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
          exp_rv = 1'b1; exp_known = q[0].known; exp_w = q[0].d;
          void'(q.pop_front());
        end
        cyc++;
        @(negedge clk);
      end
      MR = 1'b0; MW = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
